ysyx_22041412_ifu: RTL and testbench



---
 rtl/ysyx_22041412_ifu.sv | 122 ++++++++++++
 tb/tb_ysyx_22041412_ifu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues word requests to imem and queues responses for decode.
// Optional performance counters are enabled by defining YSYX_22041412_IFU_PERF_EN.
module ysyx_22041412_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
`ifdef YSYX_22041412_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_drop_cnt
`endif
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(IBUF_DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [63:0]   q_pc    [IBUF_DEPTH];
  logic [31:0]   q_instr [IBUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop;
  logic [CW:0]   credit_used;

  logic req_fire;
  logic rsp_fire;
  logic rsp_drop;
  logic push;
  logic pop;

  // Buffered plus in-flight words may never exceed the queue size, so every response has a slot.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_fire && ((drop != '0) || redirect_valid);
  assign push     = rsp_fire && !rsp_drop;
  assign pop      = instr_valid && instr_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  // A redirect empties the queue and marks everything still in flight as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 64'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (rsp_drop) drop <= drop - 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef YSYX_22041412_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (rsp_drop) perf_drop_cnt <= perf_drop_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Testbench for ysyx_22041412_ifu: directed vector table, corner sequences, and randomized traffic
// checked against a queue-based reference model.
module tb_ysyx_22041412_ifu;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
`ifdef YSYX_22041412_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_drop_cnt;
`endif

  ysyx_22041412_ifu #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef YSYX_22041412_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } entry_t;

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        rq_rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_reqv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  // Reference model: plain queue of buffered {pc, word} plus integer credit/discard counts.
  logic [63:0] m_fetch_pc;
  logic [63:0] m_rsp_pc;
  entry_t      m_q[$];
  int          m_outs;
  int          m_drop;
  logic [63:0] m_fetch_cnt;
  logic [63:0] m_drop_cnt;
  logic [63:0] pending[$];

  int   checks;
  int   errors;
  vec_t vecs[14];

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [63:0] randPc();
    logic [63:0] p;
    case ($urandom_range(0, 7))
      0:       p = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      1:       p = {32'($urandom), 32'($urandom)};
      2:       p = RESET_PC + 64'($urandom_range(0, 1023));
      default: p = RESET_PC + 64'($urandom_range(0, 255) * 4);
    endcase
    return p;
  endfunction

  task automatic modelReset();
    m_fetch_pc  = RESET_PC;
    m_rsp_pc    = RESET_PC;
    m_q.delete();
    m_outs      = 0;
    m_drop      = 0;
    m_fetch_cnt = '0;
    m_drop_cnt  = '0;
  endtask

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic m_reqv;
    logic m_iv;
    m_reqv = !redirect_valid && ((m_q.size() + m_outs) < DEPTH);
    m_iv   = (m_q.size() != 0) && !redirect_valid;
    checkVal("req_valid", 64'(imem_req_valid), 64'(m_reqv));
    checkVal("req_addr", imem_req_addr, m_fetch_pc);
    checkVal("instr_valid", 64'(instr_valid), 64'(m_iv));
    if (m_iv) begin
      checkVal("instr", 64'(instr), 64'(m_q[0].word));
      checkVal("instr_pc", instr_pc, m_q[0].pc);
    end
`ifdef YSYX_22041412_IFU_PERF_EN
    checkVal("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
    checkVal("perf_drop_cnt", perf_drop_cnt, m_drop_cnt);
`endif
  endtask

  task automatic modelUpdate();
    logic   m_reqv;
    logic   m_iv;
    logic   acc;
    entry_t e;
    m_reqv = !redirect_valid && ((m_q.size() + m_outs) < DEPTH);
    m_iv   = (m_q.size() != 0) && !redirect_valid;
    acc    = imem_rsp_valid && (m_outs > 0);
    if (m_iv && instr_ready) begin
      void'(m_q.pop_front());
      m_fetch_cnt += 64'd1;
    end
    if (acc) begin
      m_outs--;
      if (m_drop > 0 || redirect_valid) begin
        if (m_drop > 0) m_drop--;
        m_drop_cnt += 64'd1;
      end else begin
        e.pc   = m_rsp_pc;
        e.word = imem_rsp_data;
        m_q.push_back(e);
        m_rsp_pc += 64'd4;
      end
    end
    if (m_reqv && imem_req_ready) begin
      m_fetch_pc += 64'd4;
      m_outs++;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_fetch_pc = redirect_pc;
      m_rsp_pc   = redirect_pc;
      m_drop     = m_outs;
    end
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs, then advance model and memory.
  task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic rq_rdy,
                               input logic rv, input logic [31:0] rd, input logic ir);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq_rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    instr_ready    = ir;
    #1;
    checkOutput();
    if (rv && pending.size() > 0) void'(pending.pop_front());
    if (imem_req_valid && imem_req_ready) pending.push_back(imem_req_addr);
    modelUpdate();
  endtask

  task automatic memCycle(input logic redir, input logic [63:0] rpc, input logic rq_rdy,
                          input logic allow, input logic ir);
    if (allow && pending.size() > 0) applyStimulus(redir, rpc, rq_rdy, 1'b1, memWord(pending[0]), ir);
    else applyStimulus(redir, rpc, rq_rdy, 1'b0, 32'h0, ir);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    checkVal({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    checkVal({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    checkVal({tag, "_instr"}, 64'(instr), 64'd0);
    checkVal({tag, "_instr_pc"}, instr_pc, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b0, 64'h0,           1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0000, 1'b0, 32'h0,         64'h0};
    vecs[1]  = '{1'b0, 64'h0,           1'b1, 1'b1, 32'hDA5A_0013, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 32'h0,         64'h0};
    vecs[2]  = '{1'b0, 64'h0,           1'b1, 1'b1, 32'hDA5A_0017, 1'b1, 1'b0, 64'h8000_0008, 1'b1, 32'hDA5A_0013, 64'h8000_0000};
    vecs[3]  = '{1'b0, 64'h0,           1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0008, 1'b1, 32'hDA5A_0017, 64'h8000_0004};
    vecs[4]  = '{1'b0, 64'h0,           1'b1, 1'b1, 32'hDA5A_001B, 1'b0, 1'b0, 64'h8000_000C, 1'b1, 32'hDA5A_0017, 64'h8000_0004};
    vecs[5]  = '{1'b0, 64'h0,           1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h8000_000C, 1'b1, 32'hDA5A_0017, 64'h8000_0004};
    vecs[6]  = '{1'b0, 64'h0,           1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h8000_000C, 1'b1, 32'hDA5A_0017, 64'h8000_0004};
    vecs[7]  = '{1'b0, 64'h0,           1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_000C, 1'b1, 32'hDA5A_001B, 64'h8000_0008};
    vecs[8]  = '{1'b0, 64'h0,           1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_000C, 1'b0, 32'h0,         64'h0};
    vecs[9]  = '{1'b1, 64'h8000_0100,   1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 64'h8000_000C, 1'b0, 32'h0,         64'h0};
    vecs[10] = '{1'b0, 64'h0,           1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0100, 1'b0, 32'h0,         64'h0};
    vecs[11] = '{1'b0, 64'h0,           1'b0, 1'b1, 32'hDA5A_0113, 1'b1, 1'b1, 64'h8000_0104, 1'b0, 32'h0,         64'h0};
    vecs[12] = '{1'b0, 64'h0,           1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0104, 1'b1, 32'hDA5A_0113, 64'h8000_0100};
    vecs[13] = '{1'b0, 64'h0,           1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0104, 1'b0, 32'h0,         64'h0};

    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    modelReset();
    #1 rst_n = 1'b0;
    #2 checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].redir, vecs[i].rpc, vecs[i].rq_rdy, vecs[i].rv, vecs[i].rd, vecs[i].ir);
      checkVal($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_reqv));
      checkVal($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      checkVal($sformatf("vec%0d_instr_valid", i), 64'(instr_valid), 64'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        checkVal($sformatf("vec%0d_instr", i), 64'(instr), 64'(vecs[i].e_instr));
        checkVal($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].e_pc);
      end
    end

    $display("[TB] redirect with two responses in flight");
    memCycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    memCycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'h8000_0200, 1'b1, 1'b0, 32'h0, 1'b1);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
    checkVal("stale1_instr_valid", 64'(instr_valid), 64'd0);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
    checkVal("stale2_instr_valid", 64'(instr_valid), 64'd0);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
    memCycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    checkVal("redir_new_instr_pc", instr_pc, 64'h8000_0200);
    checkVal("redir_new_instr", 64'(instr), 64'hDA5A_0213);
`ifdef YSYX_22041412_IFU_PERF_EN
    checkVal("redir_perf_drop", perf_drop_cnt, 64'd2);
`endif
    memCycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);

    $display("[TB] redirect coincident with response and pop");
    memCycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    memCycle(1'b1, 64'h8000_0300, 1'b1, 1'b1, 1'b1);
    checkVal("coinc_instr_valid", 64'(instr_valid), 64'd0);
    memCycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    checkVal("coinc_empty_next", 64'(instr_valid), 64'd0);

    $display("[TB] reset with buffered and in-flight state");
    memCycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    checkVal("post_reset_addr", imem_req_addr, RESET_PC);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
    memCycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
    checkVal("post_reset_instr_pc", instr_pc, RESET_PC);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      logic redir;
      redir = ($urandom_range(0, 99) < 4);
      if (pending.size() == 0 && $urandom_range(0, 99) < 3)
        applyStimulus(redir, randPc(), ($urandom_range(0, 99) < 75), 1'b1, 32'($urandom),
                      ($urandom_range(0, 99) < 70));
      else
        memCycle(redir, randPc(), ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
